mux_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the one-hot N-way packed mux used in the common datapath.
- Up to NUMBER_WAYS requesters each present one SINGLE_ELEMENT_SIZE_IN_BITS-bit element plus a request.
- The block grants one requester at a time and drives the mux select as a registered one-hot vector.
- It presents the selected element downstream under a valid/ready handshake and acknowledges the winner.
- A watchdog releases a grant that stalls too long.

---
 rtl/mux_rr_arbiter.sv | 115 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for the one-hot N-way packed mux.
// It grants one requester at a time and hands its element downstream over valid/ready, with a stall watchdog.
module mux_rr_arbiter #(
    parameter int NUMBER_WAYS                 = 8,
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 4,
    parameter int TIMEOUT_CYCLES              = 16
) (
    input  logic                                               clk_in,
    input  logic                                               reset_in,
    input  logic [NUMBER_WAYS*SINGLE_ELEMENT_SIZE_IN_BITS-1:0] way_packed_in,
    input  logic [NUMBER_WAYS-1:0]                             request_in,
    input  logic                                               ready_in,
    output logic [NUMBER_WAYS-1:0]                             sel_out,
    output logic                                               valid_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             way_packed_out,
    output logic [NUMBER_WAYS-1:0]                             ack_out,
    output logic                                               timeout_out
);

    localparam int W  = SINGLE_ELEMENT_SIZE_IN_BITS;
    localparam int PW = (NUMBER_WAYS > 1) ? $clog2(NUMBER_WAYS) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [PW-1:0] PTR_RESET = PW'(NUMBER_WAYS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [NUMBER_WAYS-1:0] sel_q, sel_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic          pickFound;
    logic [PW-1:0] pickIdx;
    logic          reqGranted;
    logic          transfer;
    logic          stall;
    logic [W-1:0]  muxData;

    // Scan downward so the lowest offset after the pointer is the last (winning) assignment.
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        for (int k = NUMBER_WAYS; k >= 1; k--) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NUMBER_WAYS) idx = idx - NUMBER_WAYS;
            if (request_in[idx]) begin
                pickFound = 1'b1;
                pickIdx   = PW'(idx);
            end
        end
    end

    always_comb begin
        muxData = '0;
        for (int i = 0; i < NUMBER_WAYS; i++) begin
            if (sel_q[i]) muxData = muxData | way_packed_in[i*W +: W];
        end
    end

    assign reqGranted     = |(request_in & sel_q);
    assign valid_out      = (state_q == BUSY) && reqGranted;
    assign transfer       = valid_out && ready_in;
    assign stall          = valid_out && !ready_in;
    assign sel_out        = sel_q;
    assign way_packed_out = muxData;
    assign ack_out        = transfer ? sel_q : '0;
    assign timeout_out    = (TIMEOUT_CYCLES != 0) && stall && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    state_d = BUSY;
                    sel_d   = {{(NUMBER_WAYS-1){1'b0}}, 1'b1} << pickIdx;
                    ptr_d   = pickIdx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // Withdrawal leaves the pointer on the withdrawer, dropping it to lowest priority.
                if (transfer || !reqGranted || timeout_out) begin
                    state_d = IDLE;
                    sel_d   = '0;
                end else if (stall && (cnt_q != {CW{1'b1}})) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= PTR_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: grant order, handshake, watchdog, withdrawal and async reset.
// Expected values are hand-computed; way i carries data 4'hA ^ i.
module tb_mux_rr_arbiter;

    localparam int N = 8;
    localparam int W = 4;
    localparam int T = 16;

    logic           clk_in = 1'b0;
    logic           reset_in;
    logic [N*W-1:0] way_packed_in;
    logic [N-1:0]   request_in;
    logic           ready_in;
    logic [N-1:0]   sel_out;
    logic           valid_out;
    logic [W-1:0]   way_packed_out;
    logic [N-1:0]   ack_out;
    logic           timeout_out;

    int checks   = 0;
    int failures = 0;

    mux_rr_arbiter #(
        .NUMBER_WAYS(N),
        .SINGLE_ELEMENT_SIZE_IN_BITS(W),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .way_packed_in(way_packed_in),
        .request_in(request_in),
        .ready_in(ready_in),
        .sel_out(sel_out),
        .valid_out(valid_out),
        .way_packed_out(way_packed_out),
        .ack_out(ack_out),
        .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [W-1:0] wayData(input int i);
        logic [W-1:0] base;
        base = 4'hA;
        return base ^ W'(i);
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic rdy);
        request_in = req;
        ready_in   = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [N-1:0] sel, input logic vld,
                            input logic [W-1:0] data, input logic [N-1:0] ack, input logic to);
        checkOutput({tag, ".sel"}, 32'(sel_out), 32'(sel));
        checkOutput({tag, ".valid"}, 32'(valid_out), 32'(vld));
        checkOutput({tag, ".data"}, 32'(way_packed_out), 32'(data));
        checkOutput({tag, ".ack"}, 32'(ack_out), 32'(ack));
        checkOutput({tag, ".timeout"}, 32'(timeout_out), 32'(to));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global time limit expired");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        for (int i = 0; i < N; i++) way_packed_in[i*W +: W] = wayData(i);
        request_in = '0;
        ready_in   = 1'b0;
        reset_in   = 1'b0;
        #12;
        checkAll("reset", 8'h00, 1'b0, 4'h0, 8'h00, 1'b0);
        reset_in = 1'b1;

        // Single request on way 0, accepted immediately
        applyStimulus(8'h01, 1'b1);
        tick();
        checkAll("single.grant", 8'h01, 1'b1, 4'hA, 8'h01, 1'b0);
        tick();
        applyStimulus(8'h00, 1'b1);
        checkAll("single.idle", 8'h00, 1'b0, 4'h0, 8'h00, 1'b0);

        // Fresh reset, all ways requesting: strict rotation 0..7,0
        reset_in = 1'b0;
        #2;
        reset_in = 1'b1;
        applyStimulus(8'hFF, 1'b1);
        for (int k = 0; k <= N; k++) begin
            tick();
            checkOutput($sformatf("rr.sel%0d", k), 32'(sel_out), 32'(1) << (k % N));
            checkOutput($sformatf("rr.ack%0d", k), 32'(ack_out), 32'(1) << (k % N));
            checkOutput($sformatf("rr.data%0d", k), 32'(way_packed_out), 32'(wayData(k % N)));
            tick();
            checkOutput($sformatf("rr.bubble%0d", k), 32'(sel_out), 32'h0);
        end

        // Park the pointer on way 4, then 8'h90 must wrap: way 7 then way 4
        applyStimulus(8'h10, 1'b1);
        tick();
        checkOutput("wrap.pre", 32'(sel_out), 32'h10);
        tick();
        applyStimulus(8'h90, 1'b1);
        tick();
        checkAll("wrap.first", 8'h80, 1'b1, wayData(7), 8'h80, 1'b0);
        tick();
        checkOutput("wrap.bubble", 32'(sel_out), 32'h0);
        tick();
        checkAll("wrap.second", 8'h10, 1'b1, wayData(4), 8'h10, 1'b0);
        applyStimulus(8'h00, 1'b0);
        tick();
        checkOutput("wrap.idle", 32'(sel_out), 32'h0);

        // Watchdog: way 2 stalls for 16 cycles
        applyStimulus(8'h04, 1'b0);
        tick();
        checkAll("wd.stall1", 8'h04, 1'b1, wayData(2), 8'h00, 1'b0);
        for (int c = 2; c <= T - 1; c++) begin
            tick();
            checkOutput($sformatf("wd.noto%0d", c), 32'(timeout_out), 32'h0);
        end
        tick();
        checkAll("wd.fire", 8'h04, 1'b1, wayData(2), 8'h00, 1'b1);
        applyStimulus(8'h0C, 1'b0);
        tick();
        checkAll("wd.idle", 8'h00, 1'b0, 4'h0, 8'h00, 1'b0);
        tick();
        checkOutput("wd.next", 32'(sel_out), 32'h08);
        applyStimulus(8'h0C, 1'b1);
        checkOutput("wd.nextack", 32'(ack_out), 32'h08);
        tick();
        applyStimulus(8'h00, 1'b0);
        checkOutput("wd.nextidle", 32'(sel_out), 32'h0);

        // Ready arrives on the final watchdog cycle: transfer wins
        applyStimulus(8'h20, 1'b0);
        tick();
        checkOutput("race.grant", 32'(sel_out), 32'h20);
        for (int c = 2; c <= T - 1; c++) tick();
        checkOutput("race.preto", 32'(timeout_out), 32'h0);
        tick();
        applyStimulus(8'h20, 1'b1);
        checkAll("race.final", 8'h20, 1'b1, wayData(5), 8'h20, 1'b0);
        tick();
        applyStimulus(8'h00, 1'b0);
        checkOutput("race.idle", 32'(sel_out), 32'h0);

        // Withdrawal on way 1
        applyStimulus(8'h02, 1'b0);
        tick();
        checkOutput("wd1.valid", 32'(valid_out), 32'h1);
        applyStimulus(8'h00, 1'b1);
        checkAll("wd1.drop", 8'h02, 1'b0, wayData(1), 8'h00, 1'b0);
        tick();
        checkOutput("wd1.idle", 32'(sel_out), 32'h0);

        // Asynchronous reset in the middle of a second grant
        applyStimulus(8'h08, 1'b0);
        tick();
        checkOutput("ar.grant", 32'(sel_out), 32'h08);
        #2;
        reset_in = 1'b0;
        #1;
        checkAll("ar.reset", 8'h00, 1'b0, 4'h0, 8'h00, 1'b0);
        applyStimulus(8'hFF, 1'b1);
        reset_in = 1'b1;
        tick();
        checkAll("ar.first", 8'h01, 1'b1, 4'hA, 8'h01, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
